// File: rtl/bcd_operand_loader.sv
// -----------------------------------------------------------------------------
// bcd_operand_loader
//
// Front end for the two-digit BCD adder. The user sets two BCD digits on an
// 8-bit switch bank and presses a load key. The first accepted press captures
// operand A and the second captures operand B. The captured operands go
// straight to the adder's operand ports. Valid is high once both operands are
// held. A press whose switch setting contains a non-BCD digit is rejected and
// raises Err.
//
// Parameters:
//   DB_CYCLES : consecutive synchronized samples a key level must hold before
//               the debounced level follows it (>= 1). Use 4 in simulation and
//               500000 on the 50 MHz board.
//
// Ports:
//   Clock  in   1  system clock, rising edge
//   Reset  in   1  asynchronous, active-high; clears all state
//   SW     in   8  operand entry, SW[7:4] = tens digit, SW[3:0] = ones digit.
//                  Not synchronized; the user holds it stable around a press.
//   Load   in   1  load key, active-high, asynchronous, may bounce
//   A      out  8  first operand (BCD), to the adder's low operand port
//   B      out  8  second operand (BCD), to the adder's high operand port
//   Valid  out  1  high in READY, while A and B are both captured
//   Err    out  1  high after a rejected press, until the next accepted capture
//   Phase  out  2  00 = awaiting A, 01 = awaiting B, 10 = operands ready
// -----------------------------------------------------------------------------
module bcd_operand_loader #(
    parameter int DB_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] SW,
    input  logic       Load,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       Valid,
    output logic       Err,
    output logic [1:0] Phase
);

    // The counter must hold values up to DB_CYCLES-1. clog2(DB_CYCLES+1) keeps
    // the width at 1 or more even when DB_CYCLES is 1.
    localparam int              CNT_W    = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        GET_A = 2'b00,
        GET_B = 2'b01,
        READY = 2'b10
    } state_t;

    state_t           state;
    logic             sync1;
    logic             sync2;
    logic             db;
    logic [CNT_W-1:0] cnt;
    logic             press;
    logic             ok;

    // A digit is valid BCD when its value is 9 or less.
    function automatic logic is_bcd_digit(input logic [3:0] digit);
        return (digit <= 4'd9);
    endfunction

    function automatic logic is_bcd_byte(input logic [7:0] value);
        return is_bcd_digit(value[7:4]) && is_bcd_digit(value[3:0]);
    endfunction

    // ---- stage: two-flop synchronizer on the asynchronous key --------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= Load;
            sync2 <= sync1;
        end
    end

    // ---- stage: debouncer --------------------------------------------------
    // db follows sync2 only after sync2 has disagreed with db for DB_CYCLES
    // consecutive edges. Any sample that agrees with db restarts the count,
    // so a short pulse or a bounce leaves no residue.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (sync2 == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            db  <= ~db;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The press fires on the edge where db toggles from 0 to 1. Because the
    // FSM samples it on that same edge, SW is captured at the moment db rises.
    // A release (1 to 0) is debounced the same way but produces no event.
    assign press = !db && sync2 && (cnt == CNT_LAST);
    assign ok    = is_bcd_byte(SW);

    // ---- stage: operand capture FSM with registered outputs ----------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= GET_A;
            A     <= 8'h00;
            B     <= 8'h00;
            Valid <= 1'b0;
            Err   <= 1'b0;
        end else if (press) begin
            case (state)
                GET_A: begin
                    if (ok) begin
                        A     <= SW;
                        Err   <= 1'b0;
                        state <= GET_B;
                    end else begin
                        Err   <= 1'b1;
                    end
                end
                GET_B: begin
                    if (ok) begin
                        B     <= SW;
                        Err   <= 1'b0;
                        Valid <= 1'b1;
                        state <= READY;
                    end else begin
                        Err   <= 1'b1;
                    end
                end
                READY: begin
                    // A new good press starts the next operand pair. The stale
                    // B is cleared so the adder never sees a mixed pair.
                    if (ok) begin
                        A     <= SW;
                        B     <= 8'h00;
                        Valid <= 1'b0;
                        Err   <= 1'b0;
                        state <= GET_B;
                    end else begin
                        Err   <= 1'b1;
                    end
                end
                default: begin
                    // The unused encoding recovers to a clean start.
                    A     <= 8'h00;
                    B     <= 8'h00;
                    Valid <= 1'b0;
                    Err   <= 1'b0;
                    state <= GET_A;
                end
            endcase
        end
    end

    assign Phase = state;

endmodule

// File: tb/tb_bcd_operand_loader.sv
module tb_bcd_operand_loader;

    logic       Clock;
    logic       Reset;
    logic [7:0] SW;
    logic       Load;
    logic [7:0] A;
    logic [7:0] B;
    logic       Valid;
    logic       Err;
    logic [1:0] Phase;

    int errors = 0;
    int checks = 0;

    bcd_operand_loader #(.DB_CYCLES(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .SW    (SW),
        .Load  (Load),
        .A     (A),
        .B     (B),
        .Valid (Valid),
        .Err   (Err),
        .Phase (Phase)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                             input logic ev, input logic ee, input logic [1:0] ep);
        check({tag, ".A"}, 32'(A), 32'(ea));
        check({tag, ".B"}, 32'(B), 32'(eb));
        check({tag, ".Valid"}, 32'(Valid), 32'(ev));
        check({tag, ".Err"}, 32'(Err), 32'(ee));
        check({tag, ".Phase"}, 32'(Phase), 32'(ep));
    endtask

    // Synchronous-looking one-cycle reset pulse, then idle low.
    task automatic pulse_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    // Clean press: 6 high samples (capture lands on the 6th edge), then a
    // release long enough for db to fall back to 0.
    task automatic do_press(input logic [7:0] sw);
        SW   = sw;
        Load = 1'b1;
        repeat (6) tick();
        Load = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        Reset = 1'b1;
        SW    = 8'h00;
        Load  = 1'b0;
        repeat (2) tick();
        Reset = 1'b0;
        tick();
        check_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);

        // Basic entry with latency: capture at edge k+5.
        SW   = 8'h37;
        Load = 1'b1;
        repeat (5) tick();
        check("lat_before.A", 32'(A), 32'h00);
        check("lat_before.Phase", 32'(Phase), 32'h0);
        tick();
        check("lat_at.A", 32'(A), 32'h37);
        check("lat_at.Phase", 32'(Phase), 32'h1);
        // Held high: still only one press.
        SW = 8'h55;
        repeat (10) tick();
        check("hold_one.Phase", 32'(Phase), 32'h1);
        check("hold_one.B", 32'(B), 32'h00);
        Load = 1'b0;
        repeat (8) tick();
        do_press(8'h45);
        check_all("second", 8'h37, 8'h45, 1'b1, 1'b0, 2'b10);

        // Short 3-sample pulse gives nothing; a 4-sample press captures.
        pulse_reset();
        SW   = 8'h21;
        Load = 1'b1;
        repeat (3) tick();
        Load = 1'b0;
        repeat (10) tick();
        check_all("short", 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);
        Load = 1'b1;
        repeat (4) tick();
        Load = 1'b0;
        tick();
        check("four.before", 32'(A), 32'h00);
        tick();
        check("four.A", 32'(A), 32'h21);
        check("four.Phase", 32'(Phase), 32'h1);
        repeat (8) tick();

        // Bouncy press 1,0,1,1,0 then steady high.
        SW = 8'h88;
        Load = 1'b1; tick();
        Load = 1'b0; tick();
        Load = 1'b1; tick();
        tick();
        Load = 1'b0; tick();
        Load = 1'b1;
        repeat (5) tick();
        check("bounce.early_B", 32'(B), 32'h00);
        check("bounce.early_Phase", 32'(Phase), 32'h1);
        tick();
        check_all("bounce.cap", 8'h21, 8'h88, 1'b1, 1'b0, 2'b10);
        repeat (4) tick();
        // Release bounce 0,1,0,1,1,0 then low.
        SW = 8'h66;
        Load = 1'b0; tick();
        Load = 1'b1; tick();
        Load = 1'b0; tick();
        Load = 1'b1; tick();
        tick();
        Load = 1'b0;
        repeat (10) tick();
        check_all("release", 8'h21, 8'h88, 1'b1, 1'b0, 2'b10);

        // Non-BCD in GET_B, then a good one.
        pulse_reset();
        do_press(8'h51);
        do_press(8'h3A);
        check_all("getb_bad", 8'h51, 8'h00, 1'b0, 1'b1, 2'b01);
        do_press(8'h09);
        check_all("getb_good", 8'h51, 8'h09, 1'b1, 1'b0, 2'b10);

        // Non-BCD in GET_A.
        pulse_reset();
        do_press(8'hA0);
        check_all("geta_bad", 8'h00, 8'h00, 1'b0, 1'b1, 2'b00);

        // READY handling.
        do_press(8'h99);
        do_press(8'h99);
        check_all("ready99", 8'h99, 8'h99, 1'b1, 1'b0, 2'b10);
        do_press(8'h12);
        check_all("ready_new", 8'h12, 8'h00, 1'b0, 1'b0, 2'b01);
        do_press(8'hF0);
        check_all("f0_getb", 8'h12, 8'h00, 1'b0, 1'b1, 2'b01);
        do_press(8'h34);
        check_all("ready_again", 8'h12, 8'h34, 1'b1, 1'b0, 2'b10);
        do_press(8'hF0);
        check_all("f0_ready", 8'h12, 8'h34, 1'b1, 1'b1, 2'b10);

        // Reset mid-debounce (cnt=2 after edges k..k+3), Load kept high.
        pulse_reset();
        do_press(8'h11);
        check("pre_mid.Phase", 32'(Phase), 32'h1);
        SW   = 8'h22;
        Load = 1'b1;
        repeat (4) tick();
        check("mid.cnt", 32'(dut.cnt), 32'h2);
        Reset = 1'b1;
        #1;
        check_all("async_rst", 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);
        tick();
        Reset = 1'b0;
        SW    = 8'h63;
        repeat (5) tick();
        check("post_rst.early", 32'(A), 32'h00);
        tick();
        check_all("post_rst.cap", 8'h63, 8'h00, 1'b0, 1'b0, 2'b01);
        Load = 1'b0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
